// File: rtl/matmul_seq.sv
// Sequencer for C = A x B: walks (i,j) row-major with k innermost, drives A/B reads,
// accumulates with one signed MAC and writes each finished C element.
module matmul_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_DIM    = 32,
   parameter int ACC_WIDTH  = 38,
   parameter int IDX_W      = $clog2(MAX_DIM),
   parameter int DIM_W      = $clog2(MAX_DIM + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic        [DIM_W-1:0]      cfg_rows,
   input  logic        [DIM_W-1:0]      cfg_inner_a,
   input  logic        [DIM_W-1:0]      cfg_inner_b,
   input  logic        [DIM_W-1:0]      cfg_cols,
   output logic                         a_rd_en,
   output logic        [IDX_W-1:0]      a_rd_row,
   output logic        [IDX_W-1:0]      a_rd_col,
   input  logic signed [DATA_WIDTH-1:0] a_rd_data,
   output logic                         b_rd_en,
   output logic        [IDX_W-1:0]      b_rd_row,
   output logic        [IDX_W-1:0]      b_rd_col,
   input  logic signed [DATA_WIDTH-1:0] b_rd_data,
   output logic                         c_wr_en,
   output logic        [IDX_W-1:0]      c_wr_row,
   output logic        [IDX_W-1:0]      c_wr_col,
   output logic signed [DATA_WIDTH-1:0] c_wr_data,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);
   localparam int               PROD_W = 2 * DATA_WIDTH;
   localparam logic [DIM_W-1:0] MAX_D  = DIM_W'(MAX_DIM);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
   state_t state, state_nxt;

   logic [DIM_W-1:0] n_q, m_q, q_q;
   logic [IDX_W-1:0] i_q, j_q, k_q;
   logic             err_q, drain_q;
   logic             cfg_bad, cfg_empty;
   logic             k_wrap, j_wrap, i_wrap, last_read, rd_en;

   logic                         vld_p0, first_p0, last_p0;
   logic        [IDX_W-1:0]      row_p0, col_p0;
   logic signed [PROD_W-1:0]     prod_p0;
   logic signed [ACC_WIDTH-1:0]  sum_p0, acc_p1;

   function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
      return {{(ACC_WIDTH - PROD_W){p[PROD_W-1]}}, p};
   endfunction

   // Two's-complement wrap of the exact sum; no saturation.
   function automatic logic signed [DATA_WIDTH-1:0] wrap_acc(input logic signed [ACC_WIDTH-1:0] s);
      return s[DATA_WIDTH-1:0];
   endfunction

   assign cfg_bad   = (cfg_inner_a != cfg_inner_b) || (cfg_rows > MAX_D) ||
                      (cfg_inner_a > MAX_D) || (cfg_inner_b > MAX_D) || (cfg_cols > MAX_D);
   assign cfg_empty = (cfg_rows == '0) || (cfg_inner_a == '0) || (cfg_cols == '0);

   assign k_wrap    = (DIM_W'(k_q) == m_q - DIM_W'(1));
   assign j_wrap    = (DIM_W'(j_q) == q_q - DIM_W'(1));
   assign i_wrap    = (DIM_W'(i_q) == n_q - DIM_W'(1));
   assign last_read = k_wrap && j_wrap && i_wrap;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (cfg_bad || cfg_empty) state_nxt = FIN;
               else                      state_nxt = RUN;
            end
         end
         RUN: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            if (last_read) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_q) state_nxt = FIN;
         end
         FIN: begin
            done      = 1'b1;
            err       = err_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign a_rd_en  = rd_en;
   assign b_rd_en  = rd_en;
   assign a_rd_row = rd_en ? i_q : '0;
   assign a_rd_col = rd_en ? k_q : '0;
   assign b_rd_row = rd_en ? k_q : '0;
   assign b_rd_col = rd_en ? j_q : '0;

   // Command latch and (i,j,k) walk; drain_q marks the second DRAIN cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         n_q     <= '0;
         m_q     <= '0;
         q_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         err_q   <= 1'b0;
         drain_q <= 1'b0;
      end else begin
         drain_q <= (state == DRAIN);
         if (state == IDLE && start) begin
            n_q   <= cfg_rows;
            m_q   <= cfg_inner_a;
            q_q   <= cfg_cols;
            err_q <= cfg_bad;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
         end else if (rd_en) begin
            if (k_wrap) begin
               k_q <= '0;
               if (j_wrap) begin
                  j_q <= '0;
                  i_q <= i_q + 1'b1;
               end else begin
                  j_q <= j_q + 1'b1;
               end
            end else begin
               k_q <= k_q + 1'b1;
            end
         end
      end
   end

   assign prod_p0 = a_rd_data * b_rd_data;
   assign sum_p0  = first_p0 ? sext_prod(prod_p0) : acc_p1 + sext_prod(prod_p0);

   // p0: read tags aligned with returning operand data
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p0   <= 1'b0;
         first_p0 <= 1'b0;
         last_p0  <= 1'b0;
         row_p0   <= '0;
         col_p0   <= '0;
      end else begin
         vld_p0   <= rd_en;
         first_p0 <= (k_q == '0);
         last_p0  <= k_wrap;
         row_p0   <= i_q;
         col_p0   <= j_q;
      end
   end

   // p1: accumulate and register the finished element
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_p1    <= '0;
         c_wr_en   <= 1'b0;
         c_wr_row  <= '0;
         c_wr_col  <= '0;
         c_wr_data <= '0;
      end else begin
         c_wr_en <= vld_p0 && last_p0;
         if (vld_p0) acc_p1 <= sum_p0;
         if (vld_p0 && last_p0) begin
            c_wr_row  <= row_p0;
            c_wr_col  <= col_p0;
            c_wr_data <= wrap_acc(sum_p0);
         end
      end
   end

endmodule

// File: tb/tb_matmul_seq.sv
// Randomized self-checking bench for matmul_seq with a plain-arithmetic matrix model
// and behavioural A/B memories answering one cycle after each read strobe.
module tb_matmul_seq;
   localparam int DW = 16;
   localparam int IW = 5;
   localparam int MW = 6;

   logic                 clk = 1'b0;
   logic                 reset, start;
   logic        [MW-1:0] cfg_rows, cfg_inner_a, cfg_inner_b, cfg_cols;
   logic                 a_rd_en, b_rd_en, c_wr_en, busy, done, err;
   logic        [IW-1:0] a_rd_row, a_rd_col, b_rd_row, b_rd_col, c_wr_row, c_wr_col;
   logic signed [DW-1:0] a_rd_data, b_rd_data, c_wr_data;

   matmul_seq dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_rows(cfg_rows), .cfg_inner_a(cfg_inner_a), .cfg_inner_b(cfg_inner_b), .cfg_cols(cfg_cols),
      .a_rd_en(a_rd_en), .a_rd_row(a_rd_row), .a_rd_col(a_rd_col), .a_rd_data(a_rd_data),
      .b_rd_en(b_rd_en), .b_rd_row(b_rd_row), .b_rd_col(b_rd_col), .b_rd_data(b_rd_data),
      .c_wr_en(c_wr_en), .c_wr_row(c_wr_row), .c_wr_col(c_wr_col), .c_wr_data(c_wr_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   logic signed [DW-1:0] a_mem [0:31][0:31];
   logic signed [DW-1:0] b_mem [0:31][0:31];

   always @(posedge clk) begin
      if (a_rd_en) a_rd_data <= a_mem[a_rd_row][a_rd_col];
      if (b_rd_en) b_rd_data <= b_mem[b_rd_row][b_rd_col];
   end

   int vectors = 0, miscompares = 0;
   int cyc = 0, t0 = 0;
   bit mon = 1'b0;
   int md_n = 1, md_m = 1, md_q = 1;
   int rd_q[$], done_q[$], wr_cyc[$], wr_row[$], wr_col[$];
   logic signed [DW-1:0] wr_dat[$];
   int rd_bad, busy_n, busy_first, busy_last, err_n, err_lone;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      int rel, r, tot;
      if (mon) begin
         rel = cyc - t0;
         tot = md_n * md_m * md_q;
         if (a_rd_en !== b_rd_en) rd_bad++;
         if (a_rd_en) begin
            if (tot == 0) rd_bad++;
            else begin
               r = rd_q.size() % tot;
               if (a_rd_row != r / (md_m * md_q) || b_rd_col != (r / md_m) % md_q ||
                   a_rd_col != r % md_m || b_rd_row != a_rd_col) rd_bad++;
            end
            rd_q.push_back(rel);
         end
         if (c_wr_en) begin
            wr_cyc.push_back(rel);
            wr_row.push_back(int'(c_wr_row));
            wr_col.push_back(int'(c_wr_col));
            wr_dat.push_back(c_wr_data);
         end
         if (busy) begin
            if (busy_n == 0) busy_first = rel;
            busy_last = rel;
            busy_n++;
         end
         if (done) done_q.push_back(rel);
         if (err && done) err_n++;
         if (err && !done) err_lone++;
      end
   end

   task automatic clear_mon();
      rd_q.delete(); done_q.delete(); wr_cyc.delete(); wr_row.delete(); wr_col.delete(); wr_dat.delete();
      rd_bad = 0; busy_n = 0; busy_first = -1; busy_last = -1; err_n = 0; err_lone = 0;
   endtask

   task automatic run_cmd(input int n, input int ma, input int mb, input int q, input int budget, output bit to);
      @(negedge clk);
      clear_mon();
      md_n = n; md_m = ma; md_q = q;
      cfg_rows = MW'(n); cfg_inner_a = MW'(ma); cfg_inner_b = MW'(mb); cfg_cols = MW'(q);
      start = 1'b1; t0 = cyc; mon = 1'b1;
      @(negedge clk);
      start = 1'b0;
      to = 1'b1;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk);
         if (done_q.size() > 0) begin
            to = 1'b0;
            break;
         end
      end
      repeat (3) @(negedge clk);
      mon = 1'b0;
   endtask

   function automatic logic signed [DW-1:0] ref_c(input int i, input int j, input int m);
      longint s;
      s = 0;
      for (int k = 0; k < m; k++) s += longint'(a_mem[i][k]) * longint'(b_mem[k][j]);
      return s[DW-1:0];
   endfunction

   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if ({a_rd_en, b_rd_en, a_rd_row, a_rd_col, b_rd_row, b_rd_col, c_wr_en, c_wr_row, c_wr_col,
           c_wr_data, busy, done, err} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got en=%b/%b/%b busy=%b done=%b err=%b data=%0d, need all 0",
                  a_rd_en, b_rd_en, c_wr_en, busy, done, err, c_wr_data);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({a_rd_en, c_wr_en, busy, done, err} !== 5'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: got rd=%b wr=%b busy=%b done=%b err=%b, need 0", a_rd_en, c_wr_en, busy, done, err);
      end
   endtask

   task automatic test_1x1();
      bit to;
      a_mem[0][0] = 16'sd3; b_mem[0][0] = 16'sd2;
      run_cmd(1, 1, 1, 1, 20, to);
      vectors++;
      if (to || rd_q.size() != 1 || rd_q[0] != 1 || rd_bad != 0) begin
         miscompares++;
         $display("FAIL 1x1_reads: got %0d reads first@%0d bad=%0d to=%0d, need 1 read @1", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : -1, rd_bad, to);
      end
      vectors++;
      if (wr_cyc.size() != 1 || wr_row[0] != 0 || wr_col[0] != 0 || wr_dat[0] !== 16'sd6 || wr_cyc[0] != 3) begin
         miscompares++;
         $display("FAIL 1x1_write: got %0d writes first (%0d,%0d)=%0d @%0d, need (0,0)=6 @3",
                  wr_cyc.size(), (wr_row.size() > 0) ? wr_row[0] : -1, (wr_col.size() > 0) ? wr_col[0] : -1,
                  (wr_dat.size() > 0) ? wr_dat[0] : 16'sd0, (wr_cyc.size() > 0) ? wr_cyc[0] : -1);
      end
      vectors++;
      if (done_q.size() != 1 || done_q[0] != 4 || err_n != 0 || err_lone != 0 || busy_first != 1 || busy_last != 3 || busy_n != 3) begin
         miscompares++;
         $display("FAIL 1x1_ctrl: got done#%0d @%0d err=%0d busy %0d..%0d n=%0d, need done @4 err=0 busy 1..3",
                  done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, err_n + err_lone, busy_first, busy_last, busy_n);
      end
   endtask

   task automatic test_2x2();
      bit to;
      int er[4] = '{0, 0, 1, 1};
      int ec[4] = '{0, 1, 0, 1};
      int ed[4] = '{2, 7, 6, 3};
      int et[4] = '{4, 6, 8, 10};
      a_mem[0][0] = 16'sd1; a_mem[0][1] = 16'sd2; a_mem[1][0] = 16'sd3; a_mem[1][1] = 16'sd0;
      b_mem[0][0] = 16'sd2; b_mem[0][1] = 16'sd1; b_mem[1][0] = 16'sd0; b_mem[1][1] = 16'sd3;
      run_cmd(2, 2, 2, 2, 40, to);
      vectors++;
      if (to || wr_cyc.size() != 4 || rd_q.size() != 8 || rd_bad != 0) begin
         miscompares++;
         $display("FAIL 2x2_counts: got %0d writes %0d reads bad=%0d to=%0d, need 4 writes 8 reads", wr_cyc.size(), rd_q.size(), rd_bad, to);
      end
      for (int w = 0; w < 4 && w < wr_cyc.size(); w++) begin
         vectors++;
         if (wr_row[w] != er[w] || wr_col[w] != ec[w] || int'(wr_dat[w]) != ed[w] || wr_cyc[w] != et[w]) begin
            miscompares++;
            $display("FAIL 2x2_wr%0d: got (%0d,%0d)=%0d @%0d, need (%0d,%0d)=%0d @%0d",
                     w, wr_row[w], wr_col[w], wr_dat[w], wr_cyc[w], er[w], ec[w], ed[w], et[w]);
         end
      end
      vectors++;
      if (done_q.size() != 1 || done_q[0] != 11 || err_n != 0 || busy_first != 1 || busy_last != 10 || busy_n != 10) begin
         miscompares++;
         $display("FAIL 2x2_ctrl: got done#%0d @%0d err=%0d busy %0d..%0d n=%0d, need done @11 err=0 busy 1..10",
                  done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, err_n, busy_first, busy_last, busy_n);
      end
   endtask

   task automatic test_short_cmds();
      bit to;
      int cfgs[4][5] = '{'{0, 0, 0, 0, 0}, '{32, 0, 0, 32, 0}, '{10, 10, 5, 5, 1}, '{33, 4, 4, 4, 1}};
      for (int t = 0; t < 4; t++) begin
         run_cmd(cfgs[t][0], cfgs[t][1], cfgs[t][2], cfgs[t][3], 10, to);
         vectors++;
         if (to || done_q.size() != 1 || done_q[0] != 1 || err_n != cfgs[t][4] || err_lone != 0) begin
            miscompares++;
            $display("FAIL short%0d_done: got done#%0d @%0d err=%0d stray_err=%0d, need done @1 err=%0d",
                     t, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, err_n, err_lone, cfgs[t][4]);
         end
         vectors++;
         if (rd_q.size() != 0 || wr_cyc.size() != 0 || busy_n != 0 || rd_bad != 0) begin
            miscompares++;
            $display("FAIL short%0d_traffic: got %0d reads %0d writes %0d busy, need none", t, rd_q.size(), wr_cyc.size(), busy_n);
         end
      end
   endtask

   task automatic test_back_to_back();
      a_mem[0][0] = 16'sd3; b_mem[0][0] = 16'sd2;
      @(negedge clk);
      clear_mon();
      md_n = 1; md_m = 1; md_q = 1;
      cfg_rows = 6'd1; cfg_inner_a = 6'd1; cfg_inner_b = 6'd1; cfg_cols = 6'd1;
      start = 1'b1; t0 = cyc; mon = 1'b1;
      repeat (8) @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 30 && done_q.size() < 2; c++) @(posedge clk);
      repeat (3) @(negedge clk);
      mon = 1'b0;
      vectors++;
      if (rd_q.size() != 2 || rd_q[0] != 1 || rd_q[1] != 6 || done_q.size() != 2 || done_q[1] != 9) begin
         miscompares++;
         $display("FAIL b2b_timing: got %0d reads (@%0d,@%0d) %0d dones last@%0d, need reads @1,@6 dones @4,@9",
                  rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : -1, (rd_q.size() > 1) ? rd_q[1] : -1,
                  done_q.size(), (done_q.size() > 0) ? done_q[done_q.size()-1] : -1);
      end
   endtask

   task automatic test_full();
      bit to;
      int er, ec, et, nerr;
      for (int i = 0; i < 32; i++)
         for (int k = 0; k < 32; k++) begin
            a_mem[i][k] = 16'sd32767;
            b_mem[i][k] = 16'sd32767;
         end
      run_cmd(32, 32, 32, 32, 33000, to);
      vectors++;
      if (to || wr_cyc.size() != 1024 || rd_q.size() != 32768 || rd_bad != 0) begin
         miscompares++;
         $display("FAIL full_counts: got %0d writes %0d reads bad=%0d to=%0d, need 1024 writes 32768 reads", wr_cyc.size(), rd_q.size(), rd_bad, to);
      end
      nerr = 0;
      for (int w = 0; w < 1024 && w < wr_cyc.size(); w++) begin
         er = w / 32; ec = w % 32; et = (w + 1) * 32 + 2;
         vectors++;
         if (wr_row[w] != er || wr_col[w] != ec || wr_dat[w] !== 16'sd32 || wr_cyc[w] != et) begin
            miscompares++;
            if (nerr++ < 8)
               $display("FAIL full_wr%0d: got (%0d,%0d)=%0d @%0d, need (%0d,%0d)=32 @%0d", w, wr_row[w], wr_col[w], wr_dat[w], wr_cyc[w], er, ec, et);
         end
      end
      vectors++;
      if (done_q.size() != 1 || done_q[0] != 32771 || err_n != 0 || busy_last != 32770) begin
         miscompares++;
         $display("FAIL full_done: got done @%0d err=%0d busy_last=%0d, need done @32771 busy_last 32770",
                  (done_q.size() > 0) ? done_q[0] : -1, err_n, busy_last);
      end
   endtask

   task automatic test_random();
      bit to;
      int dims[2][3] = '{'{32, 16, 32}, '{16, 32, 16}};
      int n, m, q, er, ec, et, nerr;
      logic signed [DW-1:0] ed;
      for (int t = 0; t < 2; t++) begin
         n = dims[t][0]; m = dims[t][1]; q = dims[t][2];
         for (int i = 0; i < 32; i++)
            for (int k = 0; k < 32; k++) begin
               a_mem[i][k] = DW'($urandom);
               b_mem[i][k] = DW'($urandom);
            end
         run_cmd(n, m, m, q, n * m * q + 50, to);
         vectors++;
         if (to || wr_cyc.size() != n * q || rd_q.size() != n * m * q || rd_bad != 0 || done_q.size() != 1 || done_q[0] != n * m * q + 3) begin
            miscompares++;
            $display("FAIL rnd%0d_counts: got %0d writes %0d reads bad=%0d done@%0d, need %0d writes done@%0d",
                     t, wr_cyc.size(), rd_q.size(), rd_bad, (done_q.size() > 0) ? done_q[0] : -1, n * q, n * m * q + 3);
         end
         nerr = 0;
         for (int w = 0; w < n * q && w < wr_cyc.size(); w++) begin
            er = w / q; ec = w % q; et = (w + 1) * m + 2;
            ed = ref_c(er, ec, m);
            vectors++;
            if (wr_row[w] != er || wr_col[w] != ec || wr_dat[w] !== ed || wr_cyc[w] != et) begin
               miscompares++;
               if (nerr++ < 8)
                  $display("FAIL rnd%0d_wr%0d: got (%0d,%0d)=%0d @%0d, need (%0d,%0d)=%0d @%0d",
                           t, w, wr_row[w], wr_col[w], wr_dat[w], wr_cyc[w], er, ec, ed, et);
            end
         end
      end
   endtask

   task automatic test_reset_midrun();
      @(negedge clk);
      clear_mon();
      md_n = 32; md_m = 32; md_q = 32;
      cfg_rows = 6'd32; cfg_inner_a = 6'd32; cfg_inner_b = 6'd32; cfg_cols = 6'd32;
      start = 1'b1; t0 = cyc; mon = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc - t0 < 50) @(negedge clk);
      cfg_rows = 6'd2; cfg_inner_a = 6'd2; cfg_inner_b = 6'd2; cfg_cols = 6'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc - t0 < 100) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({a_rd_en, b_rd_en, a_rd_row, a_rd_col, b_rd_row, b_rd_col, c_wr_en, c_wr_row, c_wr_col,
           c_wr_data, busy, done, err} !== '0) begin
         miscompares++;
         $display("FAIL midrun_reset_outputs: got en=%b/%b/%b busy=%b row=%0d data=%0d, need all 0",
                  a_rd_en, b_rd_en, c_wr_en, busy, c_wr_row, c_wr_data);
      end
      reset = 1'b0;
      repeat (20) @(negedge clk);
      mon = 1'b0;
      vectors++;
      if (rd_q.size() != 100 || rd_q[99] != 100 || rd_bad != 0 || busy_n != 100 || busy_last != 100) begin
         miscompares++;
         $display("FAIL midrun_reads: got %0d reads last@%0d bad=%0d busy n=%0d last=%0d, need 100 reads ending @100",
                  rd_q.size(), (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : -1, rd_bad, busy_n, busy_last);
      end
      vectors++;
      if (wr_cyc.size() != 3 || wr_cyc[2] != 98 || done_q.size() != 0) begin
         miscompares++;
         $display("FAIL midrun_writes: got %0d writes last@%0d %0d dones, need 3 writes last@98 no done",
                  wr_cyc.size(), (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : -1, done_q.size());
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      cfg_rows = '0; cfg_inner_a = '0; cfg_inner_b = '0; cfg_cols = '0;
      for (int i = 0; i < 32; i++)
         for (int k = 0; k < 32; k++) begin
            a_mem[i][k] = '0;
            b_mem[i][k] = '0;
         end
      repeat (3) @(posedge clk);
      test_reset();
      test_1x1();
      test_2x2();
      test_short_cmds();
      test_back_to_back();
      test_full();
      test_random();
      test_reset_midrun();
      test_2x2();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
- Sequencer for the matrix-multiply datapath.
- Takes a start command with four dimensions, checks them, then walks C = A x B in row-major order over (i,j), with k as the innermost loop.
- Drives read ports on the A and B operand buffers and a write port on the C result buffer, using one signed multiply-accumulate.
- Sits between the command/config logic and the operand/result memories.

Parameters:
- DATA_WIDTH, 16: signed element width of A, B and C.
- MAX_DIM, 32: largest legal value of any dimension.
- ACC_WIDTH, 38: signed accumulator width; must be at least 2*DATA_WIDTH + clog2(MAX_DIM) + 1.
- IDX_W, clog2(MAX_DIM) = 5: width of row/column indices.
- DIM_W, clog2(MAX_DIM+1) = 6: width of dimension inputs.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: command strobe; sampled only in IDLE.
- cfg_rows, in, DIM_W: n, the number of rows of A.
- cfg_inner_a, in, DIM_W: m, the number of columns of A.
- cfg_inner_b, in, DIM_W: the number of rows of B.
- cfg_cols, in, DIM_W: q, the number of columns of B.
- a_rd_en, out, 1: A read strobe.
- a_rd_row, out, IDX_W: A row index (i).
- a_rd_col, out, IDX_W: A column index (k).
- a_rd_data, in, DATA_WIDTH: A element, valid 1 cycle after a_rd_en.
- b_rd_en, out, 1: B read strobe.
- b_rd_row, out, IDX_W: B row index (k).
- b_rd_col, out, IDX_W: B column index (j).
- b_rd_data, in, DATA_WIDTH: B element, valid 1 cycle after b_rd_en.
- c_wr_en, out, 1: C write strobe.
- c_wr_row, out, IDX_W: C row index (i).
- c_wr_col, out, IDX_W: C column index (j).
- c_wr_data, out, DATA_WIDTH: C element.
- busy, out, 1: command in progress.
- done, out, 1: 1-cycle pulse at command completion.
- err, out, 1: 1-cycle pulse, coincident with done, for a rejected command.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: every output is 0; FSM in IDLE; index counters, accumulator and pipeline valid/first/last flags cleared.
- Reset mid-operation: takes effect at the next edge; no read or write strobe is asserted after that edge.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - On start (call the accepting edge cycle 0), latch all dimensions.
  - If cfg_inner_a != cfg_inner_b, or any dimension > MAX_DIM: go to FIN with err=1.
  - Else if any of n, m, q is 0: go to FIN with err=0; no memory traffic.
  - Else: go to RUN with i=j=k=0.
- start outside IDLE is ignored.
- RUN:
  - Each cycle assert a_rd_en and b_rd_en with A[i][k], B[k][j]. A and B strobes are always identical.
  - Counter order: k increments first; on wrap (k == m-1) k returns to 0 and j increments; on j wrap, i increments.
  - The read for (i, q-1, m-1) is the last; the next state is DRAIN.
  - Reads for consecutive elements are back-to-back; there are no bubbles.
- Datapath pipeline:
  - A read issued at cycle c returns data at c+1.
  - At c+1 the product is a full-precision signed DATA_WIDTH x DATA_WIDTH product, sign-extended to ACC_WIDTH.
  - If the read was k==0, the accumulator is loaded with the product; otherwise it is accumulator + product.
  - If the read was k==m-1, the sum including the product is registered to c_wr_data with c_wr_en=1 and the (i,j) tag, visible at cycle c+2.
- Arithmetic: c_wr_data = low DATA_WIDTH bits of the exact sum (two's-complement wrap, no saturation). The accumulator never overflows within legal dimensions.
- DRAIN: wait 2 cycles for the final write, then go to FIN.
- FIN: assert done for 1 cycle (err too, if rejected), then return to IDLE.
- busy:
  - Is 1 from cycle 1 through the last write cycle.
  - Is 0 in the done cycle and for rejected or empty commands.
- Timing for a valid non-empty command: first read at cycle 1; last read at cycle n*q*m; last write at n*q*m+2; done at n*q*m+3. Exactly n*q writes occur, in row-major order.
- Rejected or empty command: done (and err if rejected) at cycle 1.
- A start in the same cycle as done is ignored. A new command is accepted from the next cycle.

Test Plan:
- 1x1x1, A=3, B=2 -> reads at cycle 1; c_wr_en at cycle 3 with (0,0)=6; done at cycle 4; err=0.
- 2x2x2, A=[[1,2],[3,0]], B=[[2,1],[0,3]] -> writes (0,0)=2 @4, (0,1)=7 @6, (1,0)=6 @8, (1,1)=3 @10; done @11; busy high cycles 1-10.
- All dimensions 0 -> done at cycle 1, err=0, no a_rd_en/b_rd_en/c_wr_en ever; repeat with n=32, m=0, q=32 -> same result.
- cfg_inner_a=10, cfg_inner_b=5 (n=10, q=5), and separately cfg_rows=33 -> err=done=1 at cycle 1, no memory traffic, busy stays 0.
- 32x32x32 with every A and B element = 32767 -> 1024 writes, each c_wr_data=32 (0x7FFE00020 truncated), done at cycle 32771; random data in 32x16x32 and 16x32x16 matches the reference model, wrap-truncated.
- Assert reset at cycle 100 of a 32x32x32 run -> from cycle 101 all outputs 0, no further strobes; a subsequent 2x2x2 command yields the values in the 2x2x2 scenario; start pulsed mid-run is ignored.
